// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   DATA_WIDTH_DEFAULT : default received character width in bits
//   rx_entry_t         : one buffered receive entry {frame_err, data}
package uart_pkg;

   localparam int DATA_WIDTH_DEFAULT = 8;

   typedef struct packed {
      logic                          frame_err;
      logic [DATA_WIDTH_DEFAULT-1:0] data;
   } rx_entry_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: DEPTH x WIDTH registers, one
// synchronous write port and one asynchronous read port, no reset.
//   clk   : clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module uart_fifo_mem #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and its consumer. Characters are
// pushed by a strobe that cannot be stalled; when the buffer is full and
// no pop frees a slot, the character is dropped and overflow sets.
//   clk, reset_n      : clock, synchronous active-low reset
//   ena               : global enable, all state freezes when low
//   rx_data_in        : received character
//   rx_data_in_valid  : single-cycle strobe qualifying rx_data_in
//   rx_frame_err_in   : stop-bit error flag for the strobed character
//   rd_data           : head-of-queue character (first-word-fall-through)
//   rd_frame_err      : frame-error flag of the head entry
//   rd_valid          : head entry available
//   rd_ready          : consumer accepts the head entry
//   count             : number of occupied entries
//   empty, full       : count==0, count==DEPTH
//   overflow          : sticky, a character was dropped
//   overflow_clr      : single-cycle strobe clearing overflow
//
// Read handshake: an entry transfers on a rising edge where rd_valid and
// rd_ready are both high; rd_valid never depends on rd_ready, and the head
// entry stays stable while rd_valid is high and rd_ready is low.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ena,
   input  logic [DATA_WIDTH-1:0] rx_data_in,
   input  logic                  rx_data_in_valid,
   input  logic                  rx_frame_err_in,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_frame_err,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   input  logic                  overflow_clr
);

   typedef struct packed {
      logic                  frame_err;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          push;
   logic          pop;
   logic          drop;
   entry_t        wr_entry;
   entry_t        rd_entry;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign rd_valid = ena && !empty;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign pop  = ena && rd_valid && rd_ready;
   assign push = ena && rx_data_in_valid && (!full || pop);
   assign drop = ena && rx_data_in_valid && full && !pop;

   assign wr_entry.frame_err = rx_frame_err_in;
   assign wr_entry.data      = rx_data_in;

   uart_fifo_mem #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && reset_n),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   assign rd_data      = rd_entry.data;
   assign rd_frame_err = rd_entry.frame_err;
   assign count        = count_q;
   assign overflow     = overflow_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (ena) begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         // A new drop wins over a clear in the same cycle.
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (overflow_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ena;
   logic [DW-1:0] rx_data_in;
   logic          rx_data_in_valid;
   logic          rx_frame_err_in;
   logic [DW-1:0] rd_data;
   logic          rd_frame_err;
   logic          rd_valid;
   logic          rd_ready;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          overflow_clr;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of {frame_err, data} plus the sticky overflow bit.
   logic [DW:0] exp_q[$];
   logic        exp_ovf = 1'b0;

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ena              (ena),
      .rx_data_in       (rx_data_in),
      .rx_data_in_valid (rx_data_in_valid),
      .rx_frame_err_in  (rx_frame_err_in),
      .rd_data          (rd_data),
      .rd_frame_err     (rd_frame_err),
      .rd_valid         (rd_valid),
      .rd_ready         (rd_ready),
      .count            (count),
      .empty            (empty),
      .full             (full),
      .overflow         (overflow),
      .overflow_clr     (overflow_clr)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model,
   // take the edge, then advance the model.
   task automatic cycle(input logic en, input logic v, input logic [DW-1:0] d,
                        input logic fe, input logic rr, input logic oc);
      logic        ev, full_m, pop_m, push_m, drop_m;
      logic [DW:0] head;
      ena              = en;
      rx_data_in_valid = v;
      rx_data_in       = d;
      rx_frame_err_in  = fe;
      rd_ready         = rr;
      overflow_clr     = oc;
      #1;
      if (reset_n) begin
         ev = en && (exp_q.size() > 0);
         check("rd_valid", 32'(rd_valid), 32'(ev));
         check("count", 32'(count), 32'(exp_q.size()));
         check("empty", 32'(empty), 32'(exp_q.size() == 0));
         check("full", 32'(full), 32'(exp_q.size() == DEPTH));
         check("overflow", 32'(overflow), 32'(exp_ovf));
         if (ev) begin
            head = exp_q[0];
            check("rd_data", 32'(rd_data), 32'(head[DW-1:0]));
            check("rd_frame_err", 32'(rd_frame_err), 32'(head[DW]));
         end
      end else begin
         ev = 1'b0;
      end
      full_m = (exp_q.size() == DEPTH);
      pop_m  = ev && rr;
      push_m = en && v && (!full_m || pop_m);
      drop_m = en && v && full_m && !pop_m;
      @(posedge clk);
      #1;
      if (!reset_n) begin
         exp_q.delete();
         exp_ovf = 1'b0;
      end else if (en) begin
         if (pop_m) void'(exp_q.pop_front());
         if (push_m) exp_q.push_back({fe, d});
         if (drop_m) exp_ovf = 1'b1;
         else if (oc) exp_ovf = 1'b0;
      end
   endtask

   task automatic do_reset(input logic en);
      reset_n = 1'b0;
      cycle(en, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      reset_n = 1'b1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic fe);
      cycle(1'b1, 1'b1, d, fe, 1'b0, 1'b0);
   endtask

   task automatic read_one();
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) read_one();
   endtask

   initial begin
      reset_n          = 1'b0;
      ena              = 1'b0;
      rx_data_in       = '0;
      rx_data_in_valid = 1'b0;
      rx_frame_err_in  = 1'b0;
      rd_ready         = 1'b0;
      overflow_clr     = 1'b0;
      @(posedge clk);
      #1;
      do_reset(1'b0);

      // reset state
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_overflow", 32'(overflow), 0);
      idle();
      check("rst_rd_valid", 32'(rd_valid), 0);

      // three pushes then continuous reads
      push(8'h41, 1'b0);
      check("t1_first_latency_valid", 32'(rd_valid), 1);
      check("t1_first_latency_data", 32'(rd_data), 32'h41);
      push(8'h42, 1'b0);
      push(8'h43, 1'b0);
      check("t1_count3", 32'(count), 3);
      check("t1_head41", 32'(rd_data), 32'h41);
      read_one();
      check("t1_head42", 32'(rd_data), 32'h42);
      read_one();
      check("t1_head43", 32'(rd_data), 32'h43);
      read_one();
      check("t1_count0", 32'(count), 0);
      check("t1_empty", 32'(empty), 1);

      // 17 pushes into 16 entries
      for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
      check("t2_full", 32'(full), 1);
      check("t2_ovf_before", 32'(overflow), 0);
      push(8'h10, 1'b0);
      check("t2_ovf_after", 32'(overflow), 1);
      check("t2_count16", 32'(count), 16);
      for (int i = 0; i < 16; i++) begin
         check("t2_read_seq", 32'(rd_data), 32'(i));
         read_one();
      end
      check("t2_empty_no_0x10", 32'(empty), 1);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("t2_ovf_cleared", 32'(overflow), 0);

      // full with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 1'b0);
      cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
      check("t3_count16", 32'(count), 16);
      check("t3_ovf0", 32'(overflow), 0);
      for (int i = 0; i < 15; i++) read_one();
      check("t3_last_aa", 32'(rd_data), 32'hAA);
      read_one();
      check("t3_empty", 32'(empty), 1);

      // empty with push and rd_ready together: push only
      cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
      check("t3b_count1", 32'(count), 1);
      check("t3b_head", 32'(rd_data), 32'h3C);
      read_one();

      // frame error alignment
      push(8'h55, 1'b1);
      push(8'h56, 1'b0);
      check("t4_fe1", 32'(rd_frame_err), 1);
      check("t4_d55", 32'(rd_data), 32'h55);
      read_one();
      check("t4_fe0", 32'(rd_frame_err), 0);
      check("t4_d56", 32'(rd_data), 32'h56);
      read_one();

      // streaming with concurrent reads past the pointer wrap
      for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'(i % 3 == 0), 1'b1, 1'b0);
      drain();
      check("t5_empty", 32'(empty), 1);

      // overflow_clr coinciding with a drop
      for (int i = 0; i < 16; i++) push(8'(i + 1), 1'b0);
      cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
      check("t5_set_wins", 32'(overflow), 1);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      drain();

      // ena low freezes everything, then reset mid-stream
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h03, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
         check("t6_hold_count", 32'(count), 3);
         check("t6_rd_valid0", 32'(rd_valid), 0);
      end
      do_reset(1'b1);
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_empty", 32'(empty), 1);
      push(8'h77, 1'b0);
      check("t6_new_head", 32'(rd_data), 32'h77);
      read_one();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_rx_fifo
